// File: rtl/uart_hex_tx.sv
// Prints each accepted 4-bit value as one ASCII hex character on an 8N1 UART line,
// optionally followed by CR LF. TX, READY and BUSY are all registered.
module uart_hex_tx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter bit          SEND_CRLF    = 1'b1
) (
  input  logic       CLKIN,
  input  logic       RESETN,
  input  logic       VALID,
  input  logic [3:0] DATA,
  output logic       READY,
  output logic       BUSY,
  output logic       TX
);

  localparam int unsigned   BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [1:0]    r_idx;
  logic          r_tx;
  logic          r_ready;
  logic          r_busy;
  logic          w_accept;
  logic          w_baud_done;
  logic          w_more;
  logic          w_tx;
  logic          w_ready;

  function automatic logic [7:0] hex_ascii(input logic [3:0] d);
    if (d < 4'd10) begin
      return 8'h30 + {4'h0, d};
    end else begin
      return 8'h37 + {4'h0, d};
    end
  endfunction

  // r_ready is only ever high while the FSM sits in IDLE, so it alone gates capture.
  assign w_accept    = VALID && r_ready;
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_more      = SEND_CRLF && (r_idx < 2'd2);

  // State register
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_START;
        else          w_next = S_IDLE;
      end
      S_START: begin
        if (w_baud_done) w_next = S_DATA;
        else             w_next = S_START;
      end
      S_DATA: begin
        if (w_baud_done && (r_bit == 3'd7)) w_next = S_STOP;
        else                                w_next = S_DATA;
      end
      S_STOP: begin
        if (w_baud_done) w_next = w_more ? S_START : S_IDLE;
        else             w_next = S_STOP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode, registered below so the pin lags the state by one cycle
  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      S_START: w_tx = 1'b0;
      S_DATA:  w_tx = r_shift[0];
      default: w_tx = 1'b1;
    endcase
    if ((r_state == S_IDLE) && !w_accept) begin
      w_ready = 1'b1;
    end else begin
      w_ready = 1'b0;
    end
  end

  // Registered pin outputs
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_tx    <= w_tx;
      r_ready <= w_ready;
      r_busy  <= !w_ready;
    end
  end

  // Baud counter restarts on every state entry and on each bit wrap
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      r_baud <= {BW{1'b0}};
    end else if ((w_next != r_state) || (r_state == S_IDLE) || w_baud_done) begin
      r_baud <= {BW{1'b0}};
    end else begin
      r_baud <= r_baud + BW'(1);
    end
  end

  // Character shifter, bit counter and message byte index
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      r_shift <= 8'h00;
      r_bit   <= 3'd0;
      r_idx   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift <= hex_ascii(DATA);
            r_idx   <= 2'd0;
            r_bit   <= 3'd0;
          end
        end
        S_START: r_bit <= 3'd0;
        S_DATA: begin
          if (w_baud_done) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
          end
        end
        S_STOP: begin
          if (w_baud_done && w_more) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= (r_idx == 2'd0) ? 8'h0D : 8'h0A;
          end
        end
        default: r_bit <= 3'd0;
      endcase
    end
  end

  assign TX    = r_tx;
  assign READY = r_ready;
  assign BUSY  = r_busy;

endmodule
